// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial unsigned subtractor, LSB first.
// Produces {borrow, a-b} after WIDTH busy cycles, valid/ready on both sides.
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   diff,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             br;
  logic [WIDTH:0]   res;

  logic             accept;
  logic             last;
  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_lo_nxt;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign diff      = res;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == LAST);

  assign a_bit  = a_sh[0];
  assign b_bit  = b_sh[0];
  assign d_bit  = a_bit ^ b_bit ^ br;
  assign br_nxt = (~a_bit & b_bit)
                | (~(a_bit ^ b_bit) & br);

  // Merge the current difference bit into slot cnt of the result.
  always_comb begin
    res_lo_nxt = res[WIDTH-1:0];
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) == cnt) begin
        res_lo_nxt[i] = d_bit;
      end
    end
  end

  // State register; reset overrides any pending transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic for the accept / shift / deliver sequence.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, then one bit per BUSY cycle.
  // The result only changes in BUSY so it survives the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      res  <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          a_sh <= a;
          b_sh <= b;
          cnt  <= '0;
          br   <= 1'b0;
        end
        busy: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
          br   <= br_nxt;
          res[WIDTH-1:0] <= res_lo_nxt;
          if (last) begin
            res[WIDTH] <= br_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub4.sv
// tb_serial_sub4: directed and exhaustive checks
// for the bit-serial subtractor.
module tb_serial_sub4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] diff;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_checks;
  int n_fail;
  int n_results;

  serial_sub4 #(
    .WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .diff     (diff),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation with out_ready held high; checks latency too.
  task automatic run_op(
    input logic [3:0] ta,
    input logic [3:0] tb,
    input logic [4:0] exp,
    input string      tag
  );
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int k = 1; k < 4; k++) begin
      step();
      check({tag, "_early"}, 32'(out_valid), 32'd0);
    end
    step();
    check({tag, "_ov"}, 32'(out_valid), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(exp));
    step();
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
    check({tag, "_ovlo"}, 32'(out_valid), 32'd0);
    check({tag, "_keep"}, 32'(diff), 32'(exp));
    out_ready = 1'b0;
  endtask

  initial begin
    logic       seen;
    logic       got;
    logic [4:0] exp;
    int         n;

    n_checks  = 0;
    n_fail    = 0;
    n_results = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 4'd0;
    b         = 4'd0;
    step();
    rst = 1'b0;
    check("rst_ir", 32'(in_ready), 32'd1);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);

    run_op(4'd1, 4'd1, 5'b00000, "1m1");
    run_op(4'd0, 4'd1, 5'b11111, "0m1");
    run_op(4'd15, 4'd1, 5'b01110, "15m1");
    run_op(4'd0, 4'd15, 5'b10001, "0m15");
    run_op(4'd15, 4'd0, 5'b01111, "15m0");
    run_op(4'd6, 4'd6, 5'b00000, "6m6");

    // Backpressure plus ignored inputs while busy / done.
    a = 4'd9;
    b = 4'd3;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    a = 4'd15;
    b = 4'd0;
    repeat (4) step();
    for (int k = 0; k < 5; k++) begin
      check("bp_ov", 32'(out_valid), 32'd1);
      check("bp_diff", 32'(diff), 32'h06);
      check("bp_ir", 32'(in_ready), 32'd0);
      a = 4'd2;
      b = 4'd0;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("bp_ov_end", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_ir_end", 32'(in_ready), 32'd1);
    check("bp_busy_end", 32'(busy), 32'd0);
    check("bp_keep", 32'(diff), 32'h06);

    // Reset on the second busy cycle.
    a = 4'd5;
    b = 4'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_ir", 32'(in_ready), 32'd1);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ov", 32'(out_valid), 32'd0);
    check("mid_diff", 32'(diff), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    check("mid_no_ov", 32'(seen), 32'd0);
    run_op(4'd7, 4'd5, 5'b00010, "7m5");

    // in_valid with rst high must not be accepted.
    rst = 1'b1;
    in_valid = 1'b1;
    a = 4'd3;
    b = 4'd1;
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    check("rstv_busy", 32'(busy), 32'd0);
    check("rstv_ir", 32'(in_ready), 32'd1);
    check("rstv_diff", 32'(diff), 32'd0);

    // Exhaustive sweep with random output backpressure.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        exp = 5'(i) - 5'(j);
        n = 0;
        while (!in_ready && n < 16) begin
          step();
          n++;
        end
        a = 4'(i);
        b = 4'(j);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        got = 1'b0;
        n = 0;
        while (!got && n < 64) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            check($sformatf("x%0d_%0d", i, j),
                  32'(diff), 32'(exp));
            n_results++;
            got = 1'b1;
          end
          step();
          n++;
        end
        out_ready = 1'b0;
        if (!got) begin
          check($sformatf("x%0d_%0d_tmo", i, j),
                32'd0, 32'd1);
        end
      end
    end
    check("x_count", 32'(n_results), 32'd256);
    check("x_idle", 32'(in_ready), 32'd1);

    if (n_fail == 0) $display("ALL_TESTS_PASSED");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
